// File: rtl/cbd_pkg.sv
// Shared constants for the cbd down-counter family: terminal-mode codes and FSM state.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cbd_pkg;

  // Terminal-mode codes. The fourth code (2'b11) behaves as wrap.
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  // RUN counts normally. EXPIRED means a one-shot has reached zero and the
  // counter is frozen until the next load or reset.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_EXPIRED = 1'b1
  } cbd_state_t;

endpackage

// File: rtl/cbd8_down_counter.sv
// Cascadable WIDTH-bit down counter with parallel load, enable, borrow chain and three terminal modes.
// Latency: Q/TC/DONE update one CLK edge after inputs; BO is combinational from BI, EN and current state.
// Backpressure: none; EN & BI gate each step, and BO stalls upper stages while the counter is expired.
//
// Ports:
//   CLK   clock, all state changes on its rising edge
//   RST   synchronous reset, active-high
//   EN    count enable
//   BI    borrow in (tie 1 on the least significant stage)
//   LD    synchronous parallel load of D; D is also kept as the reload value
//   D     load value
//   MODE  00 wrap, 01 auto-reload, 10 one-shot stop, 11 wrap
//   Q     current count (registered)
//   BO    borrow out, combinational
//   TC    registered one-cycle terminal-count pulse
//   DONE  registered, high once a one-shot has expired
module cbd8_down_counter
  import cbd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             BI,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TC,
  output logic             DONE
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rld;
  logic             tc;
  cbd_state_t       state;

  logic             at_zero;
  logic             step;

  assign at_zero = (q == '0);

  // DONE is a direct decode of the state flop, so it is still a registered output.
  assign DONE = (state == ST_EXPIRED);

  // A step needs both the local enable and the borrow from the stage below;
  // an expired one-shot ignores both until it is reloaded.
  assign step = EN & BI & ~DONE;

  // Single AND term so a chain of stages ripples borrow in one combinational path.
  assign BO = BI & EN & at_zero & ~DONE;

  assign Q  = q;
  assign TC = tc;

  // Priority: RST > LD > count step > hold.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q     <= '0;
      rld   <= '0;
      tc    <= 1'b0;
      state <= ST_RUN;
    end else if (LD) begin
      q     <= D;
      rld   <= D;
      tc    <= 1'b0;
      state <= ST_RUN;
    end else if (step) begin
      if (!at_zero) begin
        q  <= q - {{(WIDTH-1){1'b0}}, 1'b1};
        tc <= 1'b0;
      end else begin
        // Terminal count: the mode is sampled only here, so a mode change
        // during a count takes effect at the next zero.
        tc <= 1'b1;
        case (MODE)
          MODE_RELOAD: begin
            q <= rld;
          end
          MODE_ONESHOT: begin
            q     <= '0;
            state <= ST_EXPIRED;
          end
          default: begin
            q <= '1;
          end
        endcase
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cbd8_down_counter.sv
// Self-checking bench for cbd8_down_counter: directed scenarios, a two-stage cascade and randomized traffic.
// Latency: expectations for Q/TC/DONE are checked 1 time unit after each rising edge; BO before the edge.
// Backpressure: n/a (bench).
module tb_cbd8_down_counter;

  logic       CLK;
  logic       RST, EN, BI, LD;
  logic [7:0] D;
  logic [1:0] MODE;
  logic [7:0] Q;
  logic       BO, TC, DONE;

  // Cascade pair: low stage BO feeds high stage BI.
  logic       c_rst, c_en, c_ld;
  logic [15:0] c_d;
  logic [7:0] c_lo_q, c_hi_q;
  logic       c_lo_bo, c_hi_bo, c_lo_tc, c_hi_tc, c_lo_done, c_hi_done;

  int vectors;
  int miscompares;

  // Reference model state, kept as plain integers.
  int  m_q;
  int  m_rld;
  bit  m_tc;
  bit  m_done;

  cbd8_down_counter #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .BI(BI), .LD(LD), .D(D), .MODE(MODE),
    .Q(Q), .BO(BO), .TC(TC), .DONE(DONE)
  );

  cbd8_down_counter #(.WIDTH(8)) u_lo (
    .CLK(CLK), .RST(c_rst), .EN(c_en), .BI(1'b1), .LD(c_ld), .D(c_d[7:0]), .MODE(2'b00),
    .Q(c_lo_q), .BO(c_lo_bo), .TC(c_lo_tc), .DONE(c_lo_done)
  );

  cbd8_down_counter #(.WIDTH(8)) u_hi (
    .CLK(CLK), .RST(c_rst), .EN(c_en), .BI(c_lo_bo), .LD(c_ld), .D(c_d[15:8]), .MODE(2'b00),
    .Q(c_hi_q), .BO(c_hi_bo), .TC(c_hi_tc), .DONE(c_hi_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check BO before the edge, advance the model
  // from the stated rules, then check the registered outputs after the edge.
  task automatic apply(input bit rst, input bit ld, input bit en, input bit bi,
                       input logic [7:0] d, input logic [1:0] mode, input string tag);
    bit exp_bo;
    RST = rst; LD = ld; EN = en; BI = bi; D = d; MODE = mode;
    #1;
    exp_bo = bi && en && (m_q == 0) && !m_done;
    chk({tag, ".BO"}, {15'd0, BO}, {15'd0, exp_bo});
    if (rst) begin
      m_q = 0; m_rld = 0; m_tc = 0; m_done = 0;
    end else if (ld) begin
      m_q = int'(d); m_rld = int'(d); m_tc = 0; m_done = 0;
    end else if (en && bi && !m_done) begin
      if (m_q > 0) begin
        m_q = m_q - 1;
        m_tc = 0;
      end else begin
        m_tc = 1;
        if (mode == 2'b01)      m_q = m_rld;
        else if (mode == 2'b10) m_done = 1;
        else                    m_q = 255;
      end
    end else begin
      m_tc = 0;
    end
    @(posedge CLK);
    #1;
    chk({tag, ".Q"},    {8'd0, Q},     16'(m_q));
    chk({tag, ".TC"},   {15'd0, TC},   {15'd0, m_tc});
    chk({tag, ".DONE"}, {15'd0, DONE}, {15'd0, m_done});
  endtask

  task automatic chain_cycle(input bit rst, input bit ld, input bit en, input logic [15:0] d,
                             input logic [15:0] exp, input string tag);
    c_rst = rst; c_ld = ld; c_en = en; c_d = d;
    @(posedge CLK);
    #1;
    chk(tag, {c_hi_q, c_lo_q}, exp);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_q = 0; m_rld = 0; m_tc = 0; m_done = 0;
    RST = 1; LD = 0; EN = 0; BI = 0; D = 8'h00; MODE = 2'b00;
    c_rst = 1; c_ld = 0; c_en = 0; c_d = 16'h0000;
    @(posedge CLK);
    #1;

    // 1. Reset, then wrap countdown from 3.
    apply(1, 0, 1, 1, 8'h55, 2'b00, "rst");
    chk("rst.Q0", {8'd0, Q}, 16'h0000);
    apply(0, 1, 1, 1, 8'h03, 2'b00, "wrap.ld");
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 1, 8'h00, 2'b00, "wrap");
    chk("wrap.Q_after", {8'd0, Q}, 16'h00FE);

    // 2. Auto-reload from 2.
    apply(0, 1, 1, 1, 8'h02, 2'b01, "rld.ld");
    for (int i = 0; i < 7; i++) apply(0, 0, 1, 1, 8'h00, 2'b01, "rld");

    // Reload value 0: stays at 0 and pulses TC every enabled step.
    apply(0, 1, 1, 1, 8'h00, 2'b01, "rld0.ld");
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 1, 8'h00, 2'b01, "rld0");

    // 3. One-shot from 1, then a fresh load clears DONE.
    apply(0, 1, 1, 1, 8'h01, 2'b10, "os.ld");
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 1, 8'h00, 2'b10, "os");
    chk("os.DONE_held", {15'd0, DONE}, 16'h0001);
    apply(0, 1, 1, 1, 8'h04, 2'b10, "os.reld");

    // 4. Hold with BI=0, then with EN=0.
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 8'h00, 2'b00, "hold_bi");
    for (int i = 0; i < 5; i++) apply(0, 0, 0, 1, 8'h00, 2'b00, "hold_en");
    chk("hold.Q", {8'd0, Q}, 16'h0004);

    // 5. LD with RST -> reset wins; LD during an enabled step -> load wins.
    apply(1, 1, 1, 1, 8'hA5, 2'b00, "ldrst");
    apply(0, 1, 1, 1, 8'h10, 2'b00, "ld_step.a");
    apply(0, 1, 1, 1, 8'h3C, 2'b00, "ld_step.b");

    // MODE changed mid-count only matters at zero.
    apply(0, 1, 1, 1, 8'h01, 2'b00, "modechg.ld");
    apply(0, 0, 1, 1, 8'h00, 2'b10, "modechg");
    apply(0, 0, 1, 1, 8'h00, 2'b01, "modechg");
    apply(0, 0, 1, 1, 8'h00, 2'b01, "modechg");

    // 6. Two-stage cascade.
    chain_cycle(1, 0, 1, 16'h0000, 16'h0000, "chain.rst");
    chain_cycle(0, 1, 1, 16'h0100, 16'h0100, "chain.ld");
    chain_cycle(0, 0, 1, 16'h0000, 16'h00FF, "chain.borrow");
    chain_cycle(0, 0, 1, 16'h0000, 16'h00FE, "chain.low_only");
    chain_cycle(0, 0, 0, 16'h0000, 16'h00FE, "chain.hold");
    chain_cycle(0, 1, 1, 16'h0000, 16'h0000, "chain.ld0");
    chain_cycle(0, 0, 1, 16'h0000, 16'hFFFF, "chain.wrap");
    chain_cycle(0, 0, 1, 16'h0000, 16'hFFFE, "chain.after_wrap");

    // Randomized traffic against the model; small load values keep zero crossings frequent.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
            8'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
